digit_scan_ctrl: RTL and testbench

- Time-multiplexing scan controller for a 4-digit display; sits directly upstream of the 2-to-4 decoder.
- Generates the 2-bit digit select and the decoder enable.
- Presents the selected digit's 4-bit value and decimal point to the segment path.
- Buffers display data in shadow registers updated only at frame boundaries, with a blanking interval per slot to prevent ghosting.

---
 rtl/digit_scan_ctrl_if.sv | 23 ++
 rtl/digit_scan_ctrl.sv | 70 +++++++
 tb/tb_digit_scan_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/digit_scan_ctrl_if.sv
// Signal bundle between the display data source and the digit scan controller.
// The master drives display data, the slave produces decoder select/enable and segment data.
interface digit_scan_ctrl_if;
   logic [15:0] digits_in;
   logic [3:0]  dp_in;
   logic [3:0]  mask_in;
   logic        hold;
   logic [1:0]  sel;
   logic        en;
   logic [3:0]  hex_out;
   logic        dp_out;
   logic        frame_done;

   modport master (
      output digits_in, dp_in, mask_in, hold,
      input  sel, en, hex_out, dp_out, frame_done
   );

   modport slave (
      input  digits_in, dp_in, mask_in, hold,
      output sel, en, hex_out, dp_out, frame_done
   );
endinterface

// File: rtl/digit_scan_ctrl.sv
// Four-digit time-multiplexed scan controller: slot prescaler, digit select, per-slot
// blanking, and frame-synchronous shadow registers feeding the 2-to-4 decoder.
module digit_scan_ctrl #(
   parameter int DIV   = 50000,
   parameter int BLANK = 1000
) (
   input  logic              clk,
   input  logic              reset,
   digit_scan_ctrl_if.slave  bus
);

   localparam int              CW      = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0]   CNT_MAX = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;
   logic [1:0]    r_sel;
   logic [15:0]   r_sh_digits;
   logic [3:0]    r_sh_dp;
   logic [3:0]    r_sh_mask;
   logic          r_frame_done;

   logic          w_tick;
   logic          w_wrap;
   logic          w_unblank;

   assign w_tick = (r_cnt == CNT_MAX);
   assign w_wrap = w_tick && (r_sel == 2'd3);

   // NOTE: shadow registers are reset too, so the first frame is guaranteed dark.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt        <= '0;
         r_sel        <= '0;
         r_sh_digits  <= '0;
         r_sh_dp      <= '0;
         r_sh_mask    <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_wrap;
         if (w_tick) begin
            r_cnt <= '0;
            r_sel <= r_sel + 2'd1;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
         // New display data lands on the same edge that sel returns to 0.
         if (w_wrap && !bus.hold) begin
            r_sh_digits <= bus.digits_in;
            r_sh_dp     <= bus.dp_in;
            r_sh_mask   <= bus.mask_in;
         end
      end
   end

   generate
      if (BLANK == 0) begin : g_no_blank
         assign w_unblank = 1'b1;
      end else begin : g_blank
         assign w_unblank = (r_cnt >= CW'(BLANK));
      end
   endgenerate

   // Outputs decode registered state only, so input changes never reach the decoder directly.
   assign bus.sel        = r_sel;
   assign bus.en         = w_unblank && r_sh_mask[r_sel];
   assign bus.hex_out    = r_sh_digits[4*r_sel +: 4];
   assign bus.dp_out     = r_sh_dp[r_sel];
   assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench: DIV=8/BLANK=2 main instance plus a DIV=2/BLANK=1 corner instance.
module tb_digit_scan_ctrl;

   logic clk;
   logic reset;
   int   n_assert;
   int   n_fail;
   int   cyc;
   int   en_count;

   logic [15:0] f_digits;
   logic [3:0]  f_mask;
   logic [3:0]  f_dp;
   logic [1:0]  e_sel;
   int          e_cnt;

   digit_scan_ctrl_if bus_a ();
   digit_scan_ctrl_if bus_b ();

   digit_scan_ctrl #(.DIV(8), .BLANK(2)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a.slave)
   );

   digit_scan_ctrl #(.DIV(2), .BLANK(1)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      en_count = 0;
      cyc      = 0;
      reset    = 1'b1;
      bus_a.digits_in = 16'h4321;
      bus_a.dp_in     = 4'b0000;
      bus_a.mask_in   = 4'hF;
      bus_a.hold      = 1'b0;
      bus_b.digits_in = 16'h4321;
      bus_b.dp_in     = 4'b0000;
      bus_b.mask_in   = 4'hF;
      bus_b.hold      = 1'b0;

      #23;
      check("rst_sel",   32'(bus_a.sel),        32'd0);
      check("rst_en",    32'(bus_a.en),         32'd0);
      check("rst_hex",   32'(bus_a.hex_out),    32'd0);
      check("rst_dp",    32'(bus_a.dp_out),     32'd0);
      check("rst_fd",    32'(bus_a.frame_done), 32'd0);
      reset = 1'b0;

      // Frames: 0 dark, 1 = 4321/F/0, 2 = ABCD/0101/0100, 3 held, 4 = 9E5F/F/0
      for (cyc = 0; cyc <= 149; ) begin
         case (cyc / 32)
            0:       begin f_digits = 16'h0000; f_mask = 4'h0;    f_dp = 4'b0000; end
            1:       begin f_digits = 16'h4321; f_mask = 4'hF;    f_dp = 4'b0000; end
            2, 3:    begin f_digits = 16'hABCD; f_mask = 4'b0101; f_dp = 4'b0100; end
            default: begin f_digits = 16'h9E5F; f_mask = 4'hF;    f_dp = 4'b0000; end
         endcase
         e_sel = 2'((cyc / 8) % 4);
         e_cnt = cyc % 8;
         check("sel",  32'(bus_a.sel),        32'(e_sel));
         check("en",   32'(bus_a.en),         32'((e_cnt >= 2) && f_mask[e_sel]));
         check("hex",  32'(bus_a.hex_out),    32'(f_digits[4*e_sel +: 4]));
         check("dp",   32'(bus_a.dp_out),     32'(f_dp[e_sel]));
         check("fd",   32'(bus_a.frame_done), 32'((cyc != 0) && (cyc % 32 == 0)));
         if (cyc >= 32 && cyc < 64 && bus_a.en) en_count++;

         if (cyc == 40) begin
            bus_a.digits_in = 16'hABCD;
            bus_a.mask_in   = 4'b0101;
            bus_a.dp_in     = 4'b0100;
         end
         if (cyc == 70) begin
            bus_a.hold      = 1'b1;
            bus_a.digits_in = 16'h5678;
            bus_a.mask_in   = 4'hF;
            bus_a.dp_in     = 4'b0000;
         end
         if (cyc == 100) bus_a.hold = 1'b0;
         if (cyc == 127) bus_a.digits_in = 16'h9E5F;
         if (cyc == 149) break;
         next_cycle();
      end
      check("en_cycles_frame2", 32'(en_count), 32'd24);

      // Mid-slot asynchronous reset at sel=2, cnt=5, between clock edges
      #2;
      reset = 1'b1;
      #1;
      check("arst_sel", 32'(bus_a.sel),        32'd0);
      check("arst_en",  32'(bus_a.en),         32'd0);
      check("arst_hex", 32'(bus_a.hex_out),    32'd0);
      check("arst_dp",  32'(bus_a.dp_out),     32'd0);
      check("arst_fd",  32'(bus_a.frame_done), 32'd0);
      repeat (2) @(posedge clk);
      #4;
      reset = 1'b0;

      for (cyc = 0; cyc <= 16; ) begin
         check("rs_sel", 32'(bus_a.sel),        32'((cyc / 8) % 4));
         check("rs_en",  32'(bus_a.en),         32'd0);
         check("rs_fd",  32'(bus_a.frame_done), 32'd0);
         check("d2_sel", 32'(bus_b.sel),        32'((cyc / 2) % 4));
         check("d2_en",  32'(bus_b.en),         32'((cyc >= 8) && (cyc % 2 == 1)));
         check("d2_hex", 32'(bus_b.hex_out),    (cyc >= 8) ? 32'(((cyc / 2) % 4) + 1) : 32'd0);
         check("d2_fd",  32'(bus_b.frame_done), 32'((cyc == 8) || (cyc == 16)));
         if (cyc == 16) break;
         next_cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
